ob_cmd_sequencer: RTL
=====================

OB_CMD_SEQUENCER -- requirements
Module: ob_cmd_sequencer

Interface
REQ-001 SHALL have parameter DATA_SIZE, default 64, order payload width.
REQ-002 SHALL have parameter PRICE_WIDTH, default 8, price index width.
REQ-003 SHALL have parameter PTR_QUEUE, default 10, queue ID width.
REQ-004 SHALL have parameter PTR_WIDTH, default 6, slot index width within a queue.
REQ-005 SHALL have parameter CMD_DEPTH, default 4 (power of 2), input command FIFO depth.
REQ-006 SHALL have parameter MATCH_LIMIT, default 255, maximum consecutive match cycles per sweep.
REQ-007 SHALL have port clk  in  1  sole clock; all logic on rising edge.
REQ-008 SHALL have port reset  in  1  synchronous, active-high reset.
REQ-009 SHALL have ports in_valid  in  1, and in_ready  out  1; together these form the command handshake.
REQ-010 SHALL have ports in_op  in  3 (100 add, 101 match, 110 remove, 111 modify), in_side  in  1 (0 bid, 1 ask), in_price  in  PRICE_WIDTH, in_q_index  in  PTR_QUEUE, in_index  in  PTR_WIDTH, in_data  in  DATA_SIZE.
REQ-011 SHALL have ports op_flag  out  3, side  out  1, price  out  PRICE_WIDTH, op_q_index  out  PTR_QUEUE, op_index  out  PTR_WIDTH, op_data  out  DATA_SIZE; all are registered and drive the order book.
REQ-012 SHALL have port matching  in  1  order book match-in-progress, combinational response to current op_flag.
REQ-013 SHALL have ports busy  out  1; err_bad_op  out  1 (pulse); err_match_timeout  out  1 (pulse); cmd_count  out  32  (commands issued).

Function
REQ-014 SHALL accept a command on rising edge when in_valid && in_ready; in_ready = FIFO not full (registered occupancy, no combinational path from in_valid).
REQ-015 SHALL drop in_op values 000/001/010/011 at acceptance, no FIFO write, err_bad_op=1 the following cycle only.
REQ-016 SHALL FSM states: IDLE, MATCH.
REQ-017 IDLE with FIFO non-empty: SHALL pop head, load op_* outputs from it, present op_flag for exactly one cycle, increment cmd_count (wraps at 2^32).
REQ-018 IDLE with FIFO empty: op_flag SHALL be 000, other op_* outputs hold.
REQ-019 After issuing add (100) or match (101): SHALL enter MATCH; each MATCH cycle drives op_flag=101, side/price/indices unchanged, op_data=0.
REQ-020 In MATCH, cycle where op_flag=101 and matching=0: SHALL return to IDLE; next op_flag 000 or next FIFO command.
REQ-021 In MATCH, SHALL count 101 cycles per sweep (including the explicit match command); on reaching MATCH_LIMIT with matching still 1: IDLE, err_match_timeout one-cycle pulse.
REQ-022 Remove/modify SHALL stay in IDLE; back-to-back remove/modify issue on consecutive cycles.
REQ-023 Minimum latency: accept edge E0 into empty FIFO in IDLE → op_flag valid during cycle after E1 (2 cycles).
REQ-024 Simultaneous push and pop SHALL be legal when not full; occupancy unchanged; order strictly FIFO; pointers wrap modulo CMD_DEPTH.
REQ-025 busy SHALL = (state==MATCH) || FIFO non-empty || op_flag!=000.
REQ-026 Auto-match cycles SHALL NOT increment cmd_count.

Reset
REQ-027 On reset: FIFO empty, in_ready=1 the next cycle, state IDLE, op_flag=000, all other op_* =0, cmd_count=0, err pulses 0, match counter 0.
REQ-028 Reset mid-MATCH or with FIFO occupied SHALL discard all pending commands; no op issued in the cycle after reset.

Structure
REQ-029 ob_pkg SHALL hold op code constants (OP_IDLE, OP_ADD, OP_MATCH, OP_REMOVE, OP_MODIFY), side constants, shared width parameters, and the command struct (op, side, price, q_index, index, data).
REQ-030 Input buffering SHALL be a sub-module ob_cmd_fifo (synchronous, first-word-fall-through, full/empty/count outputs).

Verification
REQ-031 Add bid price 0x40 data 0x0000_0000_0005_0000, matching held 0 → op_flag 100 one cycle, then 101 one cycle, then 000; cmd_count=1.
REQ-032 Add ask, matching=1 for 3 cycles then 0 → four 101 cycles, then IDLE; busy low afterwards.
REQ-033 Fill 4 commands without draining while in MATCH → in_ready=0 on 4th; 5th held; all issue in order after sweep.
REQ-034 MATCH_LIMIT=8, matching stuck 1 → exactly eight 101 cycles, err_match_timeout pulse, IDLE.
REQ-035 in_op=010 accepted → no issue, err_bad_op one-cycle pulse, cmd_count unchanged.
REQ-036 Reset asserted during MATCH with 2 queued → next cycle op_flag=000, FIFO empty, in_ready=1, cmd_count=0.

Source files
------------

// File: rtl/ob_pkg.sv
// Shared definitions for the order-book command path: op codes, sides, default geometry,
// the command record and the sequencer state type.
package ob_pkg;

    localparam int unsigned OB_DATA_SIZE   = 64;
    localparam int unsigned OB_PRICE_WIDTH = 8;
    localparam int unsigned OB_PTR_QUEUE   = 10;
    localparam int unsigned OB_PTR_WIDTH   = 6;
    localparam int unsigned OB_CMD_DEPTH   = 4;
    localparam int unsigned OB_MATCH_LIMIT = 255;

    localparam logic [2:0] OP_IDLE   = 3'b000;
    localparam logic [2:0] OP_ADD    = 3'b100;
    localparam logic [2:0] OP_MATCH  = 3'b101;
    localparam logic [2:0] OP_REMOVE = 3'b110;
    localparam logic [2:0] OP_MODIFY = 3'b111;

    localparam logic SIDE_BID = 1'b0;
    localparam logic SIDE_ASK = 1'b1;

    typedef struct packed {
        logic [2:0]                op;
        logic                      side;
        logic [OB_PRICE_WIDTH-1:0] price;
        logic [OB_PTR_QUEUE-1:0]   q_index;
        logic [OB_PTR_WIDTH-1:0]   index;
        logic [OB_DATA_SIZE-1:0]   data;
    } cmd_t;

    typedef enum logic {
        StIdle,
        StMatch
    } seq_state_e;

    // Only the four 1xx codes are real commands.
    function automatic logic op_is_cmd(input logic [2:0] op);
        return op[2];
    endfunction

    function automatic logic op_starts_sweep(input logic [2:0] op);
        return (op == OP_ADD) || (op == OP_MATCH);
    endfunction

endpackage

// File: rtl/ob_cmd_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two (>= 2) so the
// pointers wrap naturally.
module ob_cmd_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       push_i,
    input  logic [WIDTH-1:0]           wdata_i,
    input  logic                       pop_i,
    output logic [WIDTH-1:0]           rdata_o,
    output logic                       full_o,
    output logic                       empty_o,
    output logic [$clog2(DEPTH+1)-1:0] count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push;
    logic             do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign rdata_o = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

endmodule

// File: rtl/ob_cmd_sequencer.sv
// Order-book command sequencer: buffers commands and issues one per cycle, following each
// add/match with an auto-match sweep that lasts while the book reports matching.
module ob_cmd_sequencer
    import ob_pkg::*;
#(
    parameter int unsigned DATA_SIZE   = OB_DATA_SIZE,
    parameter int unsigned PRICE_WIDTH = OB_PRICE_WIDTH,
    parameter int unsigned PTR_QUEUE   = OB_PTR_QUEUE,
    parameter int unsigned PTR_WIDTH   = OB_PTR_WIDTH,
    parameter int unsigned CMD_DEPTH   = OB_CMD_DEPTH,
    parameter int unsigned MATCH_LIMIT = OB_MATCH_LIMIT
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             in_op,
    input  logic                   in_side,
    input  logic [PRICE_WIDTH-1:0] in_price,
    input  logic [PTR_QUEUE-1:0]   in_q_index,
    input  logic [PTR_WIDTH-1:0]   in_index,
    input  logic [DATA_SIZE-1:0]   in_data,
    output logic [2:0]             op_flag,
    output logic                   side,
    output logic [PRICE_WIDTH-1:0] price,
    output logic [PTR_QUEUE-1:0]   op_q_index,
    output logic [PTR_WIDTH-1:0]   op_index,
    output logic [DATA_SIZE-1:0]   op_data,
    input  logic                   matching,
    output logic                   busy,
    output logic                   err_bad_op,
    output logic                   err_match_timeout,
    output logic [31:0]            cmd_count
);

    localparam int unsigned IDX_LSB = DATA_SIZE;
    localparam int unsigned QI_LSB  = IDX_LSB + PTR_WIDTH;
    localparam int unsigned PR_LSB  = QI_LSB + PTR_QUEUE;
    localparam int unsigned SD_LSB  = PR_LSB + PRICE_WIDTH;
    localparam int unsigned OP_LSB  = SD_LSB + 1;
    localparam int unsigned CMD_W   = OP_LSB + 3;
    localparam int unsigned CNT_W   = $clog2(MATCH_LIMIT + 1);

    logic [CMD_W-1:0]               fifo_wdata;
    logic [CMD_W-1:0]               fifo_rdata;
    logic                           fifo_full;
    logic                           fifo_empty;
    logic [$clog2(CMD_DEPTH+1)-1:0] fifo_count;
    logic                           accept;
    logic                           push;
    logic                           issue;
    logic                           leave_match;
    logic [2:0]                     head_op;

    seq_state_e             state_q;
    logic [2:0]             op_flag_q;
    logic                   side_q;
    logic [PRICE_WIDTH-1:0] price_q;
    logic [PTR_QUEUE-1:0]   q_index_q;
    logic [PTR_WIDTH-1:0]   index_q;
    logic [DATA_SIZE-1:0]   data_q;
    logic [31:0]            cmd_count_q;
    logic [CNT_W-1:0]       match_cnt_q;
    logic                   err_bad_op_q;
    logic                   err_timeout_q;

    assign in_ready   = !fifo_full;
    assign accept     = in_valid && in_ready;
    assign push       = accept && op_is_cmd(in_op);
    assign fifo_wdata = {in_op, in_side, in_price, in_q_index, in_index, in_data};
    assign head_op    = fifo_rdata[OP_LSB +: 3];

    ob_cmd_fifo #(
        .WIDTH (CMD_W),
        .DEPTH (CMD_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .push_i  (push),
        .wdata_i (fifo_wdata),
        .pop_i   (issue),
        .rdata_o (fifo_rdata),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    // A sweep ends on a 101 cycle that either found nothing or used up its budget.
    always_comb begin
        leave_match = (state_q == StMatch) && (op_flag_q == OP_MATCH)
                      && (!matching || (match_cnt_q == CNT_W'(MATCH_LIMIT)));
        issue       = !fifo_empty && ((state_q == StIdle) || leave_match);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= StIdle;
            op_flag_q     <= OP_IDLE;
            side_q        <= 1'b0;
            price_q       <= '0;
            q_index_q     <= '0;
            index_q       <= '0;
            data_q        <= '0;
            cmd_count_q   <= '0;
            match_cnt_q   <= '0;
            err_bad_op_q  <= 1'b0;
            err_timeout_q <= 1'b0;
        end else begin
            err_bad_op_q  <= accept && !op_is_cmd(in_op);
            err_timeout_q <= 1'b0;
            if ((state_q == StMatch) && !leave_match) begin
                op_flag_q   <= OP_MATCH;
                data_q      <= '0;
                match_cnt_q <= match_cnt_q + CNT_W'(1);
            end else begin
                if (leave_match) begin
                    err_timeout_q <= matching;
                end
                state_q     <= StIdle;
                match_cnt_q <= '0;
                if (issue) begin
                    op_flag_q   <= head_op;
                    side_q      <= fifo_rdata[SD_LSB];
                    price_q     <= fifo_rdata[PR_LSB +: PRICE_WIDTH];
                    q_index_q   <= fifo_rdata[QI_LSB +: PTR_QUEUE];
                    index_q     <= fifo_rdata[IDX_LSB +: PTR_WIDTH];
                    data_q      <= fifo_rdata[0 +: DATA_SIZE];
                    cmd_count_q <= cmd_count_q + 32'd1;
                    if (op_starts_sweep(head_op)) begin
                        state_q <= StMatch;
                    end
                    // An explicit match is itself the first counted 101 cycle.
                    if (head_op == OP_MATCH) begin
                        match_cnt_q <= CNT_W'(1);
                    end
                end else begin
                    op_flag_q <= OP_IDLE;
                end
            end
        end
    end

    assign op_flag           = op_flag_q;
    assign side              = side_q;
    assign price             = price_q;
    assign op_q_index        = q_index_q;
    assign op_index          = index_q;
    assign op_data           = data_q;
    assign cmd_count         = cmd_count_q;
    assign err_bad_op        = err_bad_op_q;
    assign err_match_timeout = err_timeout_q;
    assign busy              = (state_q == StMatch) || (fifo_count != '0) || (op_flag_q != OP_IDLE);

endmodule
